timer_ctrl: RTL and testbench
=============================

// Module: timer_ctrl
// PURPOSE
//  Programmable interval timer controller: sequences a prescaler counter and a period down-counter.
//  Supports one-shot and periodic modes, with start/stop/pause control and a 1-cycle expire pulse.
//  Sits between the control/CSR logic and the time-base; drives the team's counter block as prescaler.
// PARAMETERS
//  PRESCALE  8   clock cycles per timer tick (>=2); prescaler counter MAX_VAL = PRESCALE-1
//  PSC_W     4   prescaler counter width, must hold PRESCALE-1
//  CNT_W     16  width of period / remaining-count registers
// PORTS
//  i_clk      in   1      clock, rising edge
//  i_rst_n    in   1      reset, asynchronous, active-low
//  i_start    in   1      pulse: latch i_period/i_mode and start (restart if busy)
//  i_stop     in   1      pulse: abort, return to IDLE, no expire
//  i_pause    in   1      level: freeze prescaler and remaining count while high
//  i_mode     in   1      0 = one-shot, 1 = periodic; sampled with i_start
//  i_period   in   CNT_W  number of ticks per interval; sampled with i_start
//  o_busy     out  1      high in RUN or PAUSE
//  o_expire   out  1      1-cycle pulse when interval elapses
//  o_err      out  1      1-cycle pulse: i_start with i_period==0 (ignored)
//  o_remain   out  CNT_W  remaining ticks in current interval
//  o_state    out  2      FSM state encoding (debug)
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, period_q/mode_q 0; prescaler held at 0.
//  FSM: IDLE=0, RUN=1, PAUSE=2, DONE=3. Registered outputs only.
//  Priority each cycle: i_stop > i_start > i_pause.
//  IDLE: i_start & i_period!=0 -> RUN, remain<=i_period, prescaler sync-cleared (i_srst).
//        i_start & i_period==0 -> o_err pulse next cycle, stay IDLE.
//  RUN: prescaler i_cnt_en=1; each prescaler tick decrements remain.
//       tick & remain==1: o_expire pulses; periodic -> remain<=period_q, stay RUN;
//       one-shot -> remain<=0, DONE. i_pause -> PAUSE.
//  PAUSE: prescaler i_cnt_en=0, count frozen; i_pause low -> RUN, prescaler phase preserved.
//       A tick already registered when entering PAUSE is still consumed (not lost).
//  DONE: one cycle, o_busy=0, then IDLE. i_start in DONE acts as in IDLE.
//  i_start in RUN/PAUSE: restart: reload remain, re-sample mode/period, clear prescaler -> RUN.
//  i_stop any state: -> IDLE next cycle, remain<=0, prescaler cleared, no o_expire.
//  Stale-tick mask: prescaler tick ignored in the cycle after any start/restart/stop.
//  Latency: with i_start sampled at edge 0, o_expire is high the cycle after edge
//    P*PRESCALE+1 (P=period); periodic repeats exactly every P*PRESCALE cycles.
//  i_period==1 valid: expire after PRESCALE+1 edges. Max P = 2^CNT_W-1; no wrap on remain.
// STRUCTURE
//  Shared package timer_pkg: state enum (IDLE/RUN/PAUSE/DONE), MODE_ONESHOT/MODE_PERIODIC.
//  One sub-module: counter (MAX_VAL=PRESCALE-1, WIDTH=PSC_W) as prescaler; its o_tick is the tick.
//  FSM + remain/period registers in timer_ctrl.
// TESTING (PRESCALE=4)
//  One-shot P=3 start@edge0 -> o_expire high after edge 13 only; DONE 1 cycle; o_busy falls.
//  Periodic P=2 -> o_expire after edges 9,17,25; remain reloads to 2 each time.
//  Pause 5 cycles mid-interval, P=3 -> expire delayed exactly 5 cycles, remain unchanged while paused.
//  i_stop at edge 6, P=3 -> no o_expire, IDLE, remain=0; then restart -> full 13-edge latency.
//  Start P=0 -> o_err pulse 1 cycle, state stays IDLE; restart mid-RUN with P=1 -> expire after 5 edges.
//  Async reset asserted mid-RUN -> all outputs 0 immediately; no expire after release.

Source files
------------

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//   Shared types for the interval timer slice.
//   - state_e         : controller FSM state, encoding is visible on o_state
//   - MODE_ONESHOT    : interval fires once, then the timer returns to idle
//   - MODE_PERIODIC   : interval reloads from the latched period and repeats
// ---------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_if.sv
// ---------------------------------------------------------------------------
// timer_if
//   Control/status bundle between the CSR logic and the timer controller.
//   Control (master -> slave):
//     i_start  : pulse, latch i_period/i_mode and (re)start
//     i_stop   : pulse, abort without expiring
//     i_pause  : level, freeze the timer while high
//     i_mode   : 0 one-shot, 1 periodic (sampled with i_start)
//     i_period : ticks per interval (sampled with i_start)
//   Status (slave -> master):
//     o_busy, o_expire, o_err, o_remain, o_state
// ---------------------------------------------------------------------------
interface timer_if #(
  parameter int CNT_W = 16
);

  logic             i_start;
  logic             i_stop;
  logic             i_pause;
  logic             i_mode;
  logic [CNT_W-1:0] i_period;

  logic             o_busy;
  logic             o_expire;
  logic             o_err;
  logic [CNT_W-1:0] o_remain;
  logic [1:0]       o_state;

  modport master (
    output i_start, i_stop, i_pause, i_mode, i_period,
    input  o_busy, o_expire, o_err, o_remain, o_state
  );

  modport slave (
    input  i_start, i_stop, i_pause, i_mode, i_period,
    output o_busy, o_expire, o_err, o_remain, o_state
  );

endinterface

// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter
//   Free-running modulo counter used as the timer prescaler. Counts 0..MAX_VAL
//   while i_cnt_en is high and emits a registered one-cycle o_tick on the
//   wrap. Holds its count (phase) while disabled.
//   Ports:
//     i_clk     : clock, rising edge
//     i_rst_n   : asynchronous active-low reset
//     i_srst    : synchronous clear of count and tick
//     i_cnt_en  : count enable
//     o_tick    : one-cycle pulse, registered on the cycle the count wraps
// ---------------------------------------------------------------------------
module counter #(
  parameter int MAX_VAL = 7,
  parameter int WIDTH   = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_srst,
  input  logic i_cnt_en,
  output logic o_tick
);

  logic [WIDTH-1:0] cnt_q;

  // The tick only lives for one cycle: any cycle that is not a wrap drops it,
  // including disabled cycles, so a frozen prescaler never repeats a tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      o_tick <= 1'b0;
    end else if (i_srst) begin
      cnt_q  <= '0;
      o_tick <= 1'b0;
    end else if (i_cnt_en) begin
      if (cnt_q == WIDTH'(MAX_VAL)) begin
        cnt_q  <= '0;
        o_tick <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + WIDTH'(1);
        o_tick <= 1'b0;
      end
    end else begin
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//   Programmable interval timer controller. A prescaler (counter) divides the
//   clock into ticks; the controller counts ticks down from the latched
//   period and pulses o_expire when the interval elapses. One-shot and
//   periodic modes, start/restart, stop and pause control.
//   Ports:
//     i_clk   : clock, rising edge
//     i_rst_n : asynchronous active-low reset
//     bus     : timer_if slave modport (control in, status out)
//   All status outputs are registered.
// ---------------------------------------------------------------------------
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE = 8,
  parameter int PSC_W    = 4,
  parameter int CNT_W    = 16
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  timer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             mask_q, mask_d;
  logic             busy_q, busy_d;
  logic             expire_q, expire_d;
  logic             err_q, err_d;
  logic             psc_srst;
  logic             psc_en;
  logic             psc_tick;
  logic             tick;
  logic             start_ok;

  // A start with a zero period is rejected; only a valid start restarts.
  assign start_ok = bus.i_start && (bus.i_period != '0);

  // Prescaler only advances in RUN, so PAUSE freezes its phase in place.
  assign psc_en = (state_q == ST_RUN);

  // Drop any tick in the cycle right after a start/restart/stop so a tick
  // belonging to the previous interval can never decrement the new one.
  assign tick = psc_tick && !mask_q;

  counter #(
    .MAX_VAL (PRESCALE - 1),
    .WIDTH   (PSC_W)
  ) u_prescaler (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_srst   (psc_srst),
    .i_cnt_en (psc_en),
    .o_tick   (psc_tick)
  );

  // Next-state logic. Stop beats start beats pause. Ticks are consumed in
  // PAUSE as well as RUN: a tick registered on the last RUN cycle arrives
  // after the state has already moved to PAUSE and must not be lost.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    period_d = period_q;
    mode_d   = mode_q;
    mask_d   = 1'b0;
    expire_d = 1'b0;
    err_d    = 1'b0;
    psc_srst = 1'b0;

    if (bus.i_stop) begin
      state_d  = ST_IDLE;
      remain_d = '0;
      psc_srst = 1'b1;
      mask_d   = 1'b1;
    end else if (start_ok) begin
      state_d  = ST_RUN;
      remain_d = bus.i_period;
      period_d = bus.i_period;
      mode_d   = bus.i_mode;
      psc_srst = 1'b1;
      mask_d   = 1'b1;
    end else begin
      err_d = bus.i_start;
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_DONE: state_d = ST_IDLE;
        ST_RUN, ST_PAUSE: begin
          state_d = bus.i_pause ? ST_PAUSE : ST_RUN;
          if (tick) begin
            if (remain_q == CNT_W'(1)) begin
              expire_d = 1'b1;
              if (mode_q == MODE_PERIODIC) begin
                remain_d = period_q;
              end else begin
                remain_d = '0;
                state_d  = ST_DONE;
              end
            end else if (remain_q != '0) begin
              remain_d = remain_q - CNT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  // State, interval registers and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
      mask_q   <= 1'b0;
      busy_q   <= 1'b0;
      expire_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      mask_q   <= mask_d;
      busy_q   <= busy_d;
      expire_q <= expire_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_busy   = busy_q;
  assign bus.o_expire = expire_q;
  assign bus.o_err    = err_q;
  assign bus.o_remain = remain_q;
  assign bus.o_state  = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
//   Directed bench for timer_ctrl with PRESCALE=4. Edge 0 is the rising edge
//   that samples i_start; a tick is consumed PRESCALE edges after the prescaler
//   restarts plus one, so a one-shot of P ticks expires right after edge
//   4*P+1. All expected values below are worked out by hand from that rule.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;

  localparam int PRESCALE = 4;
  localparam int PSC_W    = 4;
  localparam int CNT_W    = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   passCount;
  int   pulses;

  timer_if #(.CNT_W(CNT_W)) bus ();

  timer_ctrl #(
    .PRESCALE (PRESCALE),
    .PSC_W    (PSC_W),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives every control input at once.
  task automatic applyStimulus(input logic start, input logic stop,
                               input logic pause, input logic mode,
                               input logic [CNT_W-1:0] period);
    bus.i_start  = start;
    bus.i_stop   = stop;
    bus.i_pause  = pause;
    bus.i_mode   = mode;
    bus.i_period = period;
  endtask

  // Advances n rising edges, sampling 1 ns after each, and counts expires.
  task automatic stepEdges(input int n, output int expCount);
    expCount = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_expire) expCount++;
    end
  endtask

  // Presents a start pulse across one edge (that edge is "edge 0").
  task automatic startTimer(input logic mode, input logic [CNT_W-1:0] period);
    applyStimulus(1'b1, 1'b0, 1'b0, mode, period);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, mode, period);
  endtask

  // Safety net in case the design wedges the bench.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #2;
    checkOutput("rst_state",  32'(bus.o_state),  32'(S_IDLE));
    checkOutput("rst_busy",   32'(bus.o_busy),   0);
    checkOutput("rst_expire", 32'(bus.o_expire), 0);
    checkOutput("rst_err",    32'(bus.o_err),    0);
    checkOutput("rst_remain", 32'(bus.o_remain), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-shot P=3: expire right after edge 13, DONE for one cycle.
    $display("[TB] one-shot P=3");
    startTimer(1'b0, 16'd3);
    stepEdges(5, pulses);
    checkOutput("os_remain_e5", 32'(bus.o_remain), 2);
    checkOutput("os_state_e5",  32'(bus.o_state),  32'(S_RUN));
    checkOutput("os_busy_e5",   32'(bus.o_busy),   1);
    stepEdges(7, pulses);
    checkOutput("os_no_early",  pulses, 0);
    checkOutput("os_remain_e12", 32'(bus.o_remain), 1);
    stepEdges(1, pulses);
    checkOutput("os_expire_e13", 32'(bus.o_expire), 1);
    checkOutput("os_state_e13",  32'(bus.o_state),  32'(S_DONE));
    checkOutput("os_busy_e13",   32'(bus.o_busy),   0);
    checkOutput("os_remain_e13", 32'(bus.o_remain), 0);
    stepEdges(1, pulses);
    checkOutput("os_expire_e14", 32'(bus.o_expire), 0);
    checkOutput("os_state_e14",  32'(bus.o_state),  32'(S_IDLE));

    // Periodic P=2: expires after edges 9, 17, 25 with reload to 2.
    $display("[TB] periodic P=2");
    startTimer(1'b1, 16'd2);
    stepEdges(8, pulses);
    checkOutput("per_no_early", pulses, 0);
    checkOutput("per_remain_e8", 32'(bus.o_remain), 1);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) begin
        stepEdges(7, pulses);
        checkOutput("per_gap", pulses, 0);
      end
      stepEdges(1, pulses);
      checkOutput("per_expire", 32'(bus.o_expire), 1);
      checkOutput("per_reload", 32'(bus.o_remain), 2);
      checkOutput("per_state",  32'(bus.o_state),  32'(S_RUN));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
    stepEdges(1, pulses);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
    checkOutput("per_stop_state", 32'(bus.o_state), 32'(S_IDLE));
    checkOutput("per_stop_busy",  32'(bus.o_busy),  0);

    // Pause for 5 edges (6..10): expire moves from edge 13 to edge 18.
    $display("[TB] pause P=3");
    startTimer(1'b0, 16'd3);
    stepEdges(5, pulses);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'd3);
    stepEdges(1, pulses);
    checkOutput("pz_state_e6",  32'(bus.o_state),  32'(S_PAUSE));
    checkOutput("pz_busy_e6",   32'(bus.o_busy),   1);
    checkOutput("pz_remain_e6", 32'(bus.o_remain), 2);
    stepEdges(4, pulses);
    checkOutput("pz_remain_e10", 32'(bus.o_remain), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
    stepEdges(1, pulses);
    checkOutput("pz_state_e11", 32'(bus.o_state), 32'(S_RUN));
    stepEdges(6, pulses);
    checkOutput("pz_no_early",   pulses, 0);
    checkOutput("pz_remain_e17", 32'(bus.o_remain), 1);
    stepEdges(1, pulses);
    checkOutput("pz_expire_e18", 32'(bus.o_expire), 1);
    stepEdges(1, pulses);
    checkOutput("pz_idle_e19", 32'(bus.o_state), 32'(S_IDLE));

    // Stop at edge 6: no expire; then a fresh start has full latency.
    $display("[TB] stop then restart P=3");
    startTimer(1'b0, 16'd3);
    stepEdges(5, pulses);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    stepEdges(1, pulses);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
    checkOutput("stp_state",  32'(bus.o_state),  32'(S_IDLE));
    checkOutput("stp_remain", 32'(bus.o_remain), 0);
    stepEdges(12, pulses);
    checkOutput("stp_no_expire", pulses, 0);
    startTimer(1'b0, 16'd3);
    stepEdges(12, pulses);
    checkOutput("stp_re_no_early", pulses, 0);
    stepEdges(1, pulses);
    checkOutput("stp_re_expire_e13", 32'(bus.o_expire), 1);
    stepEdges(2, pulses);

    // Zero period is rejected with a one-cycle error pulse.
    $display("[TB] zero period and mid-run restart");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    stepEdges(1, pulses);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("zero_err",   32'(bus.o_err),   1);
    checkOutput("zero_state", 32'(bus.o_state), 32'(S_IDLE));
    checkOutput("zero_busy",  32'(bus.o_busy),  0);
    stepEdges(1, pulses);
    checkOutput("zero_err_gone", 32'(bus.o_err), 0);

    // Restart mid-RUN with P=1: expire 5 edges after the restart edge.
    startTimer(1'b1, 16'd3);
    stepEdges(6, pulses);
    startTimer(1'b0, 16'd1);
    checkOutput("rs_remain", 32'(bus.o_remain), 1);
    stepEdges(4, pulses);
    checkOutput("rs_no_early", pulses, 0);
    stepEdges(1, pulses);
    checkOutput("rs_expire_e5", 32'(bus.o_expire), 1);
    checkOutput("rs_oneshot",   32'(bus.o_state),  32'(S_DONE));
    stepEdges(2, pulses);

    // Asynchronous reset in the middle of a periodic run.
    $display("[TB] async reset mid-run");
    startTimer(1'b1, 16'd2);
    stepEdges(3, pulses);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_state",  32'(bus.o_state),  32'(S_IDLE));
    checkOutput("ar_busy",   32'(bus.o_busy),   0);
    checkOutput("ar_remain", 32'(bus.o_remain), 0);
    checkOutput("ar_expire", 32'(bus.o_expire), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stepEdges(20, pulses);
    checkOutput("ar_no_expire", pulses, 0);
    checkOutput("ar_idle",      32'(bus.o_state), 32'(S_IDLE));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
